// File: rtl/mod_pkg.sv
// Shared types and default carrier increments for the LFSR modulator.
package mod_pkg;

  typedef enum logic [1:0] {
    MOD_ASK  = 2'd0,
    MOD_FSK  = 2'd1,
    MOD_BPSK = 2'd2,
    MOD_RAW  = 2'd3
  } mod_sel_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    PENDING = 2'd2
  } state_t;

  // DDS increments at 50 MHz: 258 ~ 3 Hz, 430 ~ 5 Hz.
  localparam logic [31:0] F_CARRIER = 32'd258;
  localparam logic [31:0] F_LO      = 32'd258;
  localparam logic [31:0] F_HI      = 32'd430;

endpackage

// File: rtl/zero_cross_det.sv
// Rising zero-crossing detector: previous sample negative, current sample >= 0.
module zero_cross_det #(
  parameter int W = 12
) (
  input  logic                fast_clk,
  input  logic                reset_n,
  input  logic signed [W-1:0] sample,
  output logic                zc
);

  localparam logic signed [W-1:0] ZERO = '0;

  logic signed [W-1:0] sin_prev_q;
  logic signed [W-1:0] sin_prev_d;

  // previous sample tracks the input every cycle
  always_comb begin
    sin_prev_d = sample;
  end

  // sample history register
  always_ff @(posedge fast_clk) begin
    if (!reset_n) begin
      sin_prev_q <= '0;
    end else begin
      sin_prev_q <= sin_prev_d;
    end
  end

  assign zc = (sin_prev_q < ZERO) && (sample >= ZERO);

endmodule

// File: rtl/lfsr_modulator.sv
// LFSR-symbol modulator: applies each new LFSR bit to the DDS carrier at a
// rising zero crossing (or after a timeout) in ASK, FSK, BPSK or raw mode.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | no symbol applied since reset; output held at 0
// RUN     | symbol applied, modulating with cur_bit / active mode
// PENDING | new symbol latched, waiting for zero crossing or timeout
module lfsr_modulator #(
  parameter int          W          = 12,
  parameter logic [31:0] F_CARRIER  = mod_pkg::F_CARRIER,
  parameter logic [31:0] F_LO       = mod_pkg::F_LO,
  parameter logic [31:0] F_HI       = mod_pkg::F_HI,
  parameter int          ZC_TIMEOUT = 4096
) (
  input  logic                fast_clk,
  input  logic                reset_n,
  input  logic [4:0]          lfsr_word,
  input  logic [1:0]          mod_sel,
  input  logic signed [W-1:0] sin_in,
  output logic signed [W-1:0] mod_out,
  output logic [31:0]         phase_inc,
  output logic                cur_bit,
  output logic                busy,
  output logic [7:0]          sym_count
);

  import mod_pkg::*;

  localparam int                 CNT_W    = $clog2(ZC_TIMEOUT);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(ZC_TIMEOUT - 1);
  localparam logic signed [W-1:0] S_MAX   = {1'b0, {(W-1){1'b1}}};
  localparam logic signed [W-1:0] S_MIN   = {1'b1, {(W-1){1'b0}}};

  state_t              state_q, state_d;
  logic [4:0]          prev_word_q, prev_word_d;
  logic                pend_bit_q, pend_bit_d;
  logic                cur_bit_q, cur_bit_d;
  mod_sel_t            active_mode_q, active_mode_d;
  logic [7:0]          sym_count_q, sym_count_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic signed [W-1:0] mod_out_q, mod_out_d;
  logic [31:0]         phase_inc_q, phase_inc_d;
  logic signed [W-1:0] sat_neg;
  logic                zc;
  logic                new_word;

  zero_cross_det #(.W(W)) u_zc (
    .fast_clk (fast_clk),
    .reset_n  (reset_n),
    .sample   (sin_in),
    .zc       (zc)
  );

  assign new_word    = (lfsr_word != prev_word_q);
  assign prev_word_d = lfsr_word;

  // next-state, symbol latch/apply and timeout counter
  always_comb begin
    state_d       = state_q;
    pend_bit_d    = pend_bit_q;
    cur_bit_d     = cur_bit_q;
    active_mode_d = active_mode_q;
    sym_count_d   = sym_count_q;
    cnt_d         = cnt_q;
    case (state_q)
      IDLE, RUN: begin
        if (new_word) begin
          pend_bit_d = lfsr_word[0];
          state_d    = PENDING;
        end
      end
      PENDING: begin
        // a later word replaces the pending bit, even in the apply cycle
        if (new_word) begin
          pend_bit_d = lfsr_word[0];
        end
        if (zc || (cnt_q == CNT_LAST)) begin
          cur_bit_d     = pend_bit_d;
          active_mode_d = mod_sel_t'(mod_sel);
          sym_count_d   = sym_count_q + 8'd1;
          cnt_d         = '0;
          state_d       = RUN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // output datapath; uses next bit/mode so the apply-cycle sample is already modulated
  always_comb begin
    sat_neg     = (sin_in == S_MIN) ? S_MAX : -sin_in;
    mod_out_d   = '0;
    phase_inc_d = F_CARRIER;
    if (state_q != IDLE) begin
      case (active_mode_d)
        MOD_ASK:  mod_out_d = cur_bit_d ? sin_in : '0;
        MOD_FSK: begin
          mod_out_d   = sin_in;
          phase_inc_d = cur_bit_d ? F_HI : F_LO;
        end
        MOD_BPSK: mod_out_d = cur_bit_d ? sin_in : sat_neg;
        MOD_RAW:  mod_out_d = cur_bit_d ? S_MAX : S_MIN;
        default:  mod_out_d = '0;
      endcase
    end
  end

  // state and datapath registers
  always_ff @(posedge fast_clk) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      prev_word_q   <= '0;
      pend_bit_q    <= 1'b0;
      cur_bit_q     <= 1'b0;
      active_mode_q <= MOD_ASK;
      sym_count_q   <= '0;
      cnt_q         <= '0;
      mod_out_q     <= '0;
      phase_inc_q   <= F_CARRIER;
    end else begin
      state_q       <= state_d;
      prev_word_q   <= prev_word_d;
      pend_bit_q    <= pend_bit_d;
      cur_bit_q     <= cur_bit_d;
      active_mode_q <= active_mode_d;
      sym_count_q   <= sym_count_d;
      cnt_q         <= cnt_d;
      mod_out_q     <= mod_out_d;
      phase_inc_q   <= phase_inc_d;
    end
  end

  assign mod_out   = mod_out_q;
  assign phase_inc = phase_inc_q;
  assign cur_bit   = cur_bit_q;
  assign busy      = (state_q == PENDING);
  assign sym_count = sym_count_q;

endmodule

// File: tb/tb_lfsr_modulator.sv
// Directed bench for lfsr_modulator: vector table plus hand sequences.
module tb_lfsr_modulator;

  localparam int W  = 12;
  localparam int TO = 4096;

  logic                fast_clk = 1'b0;
  logic                reset_n;
  logic [4:0]          lfsr_word;
  logic [1:0]          mod_sel;
  logic signed [W-1:0] sin_in;
  logic signed [W-1:0] mod_out;
  logic [31:0]         phase_inc;
  logic                cur_bit;
  logic                busy;
  logic [7:0]          sym_count;

  int tests = 0;
  int fails = 0;
  int exp_sc = 0;

  typedef struct {
    logic [4:0] word;
    logic [1:0] mode;
    int         sin_after;
    int         exp_out;
    int         exp_inc;
    int         exp_bit;
  } vec_t;

  vec_t vecs[11];

  lfsr_modulator #(.W(W), .ZC_TIMEOUT(TO)) dut (
    .fast_clk  (fast_clk),
    .reset_n   (reset_n),
    .lfsr_word (lfsr_word),
    .mod_sel   (mod_sel),
    .sin_in    (sin_in),
    .mod_out   (mod_out),
    .phase_inc (phase_inc),
    .cur_bit   (cur_bit),
    .busy      (busy),
    .sym_count (sym_count)
  );

  always #5 fast_clk = ~fast_clk;

  task automatic tick();
    @(posedge fast_clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // new word, then a -1 -> 0 crossing; symbol is applied on the second edge
  task automatic apply_word(input logic [4:0] w, input logic [1:0] m);
    lfsr_word = w;
    mod_sel   = m;
    sin_in    = -12'sd1;
    tick();
    sin_in    = 12'sd0;
    tick();
  endtask

  initial begin
    int n;
    vecs[0]  = '{5'b00001, 2'd0,   500,   500, 258, 1};
    vecs[1]  = '{5'b00010, 2'd0,   500,     0, 258, 0};
    vecs[2]  = '{5'b00011, 2'd2,  1000,  1000, 258, 1};
    vecs[3]  = '{5'b00100, 2'd2,  1000, -1000, 258, 0};
    vecs[4]  = '{5'b00110, 2'd2, -2048,  2047, 258, 0};
    vecs[5]  = '{5'b01000, 2'd2,    -5,     5, 258, 0};
    vecs[6]  = '{5'b01001, 2'd1,  -300,  -300, 430, 1};
    vecs[7]  = '{5'b01010, 2'd1,    77,    77, 258, 0};
    vecs[8]  = '{5'b01011, 2'd3,     0,  2047, 258, 1};
    vecs[9]  = '{5'b01100, 2'd3,   900, -2048, 258, 0};
    vecs[10] = '{5'b01101, 2'd0, -2048, -2048, 258, 1};

    reset_n   = 1'b0;
    lfsr_word = 5'd0;
    mod_sel   = 2'd0;
    sin_in    = '0;
    tick();
    tick();
    check("rst_mod_out", int'(mod_out), 0);
    check("rst_phase_inc", int'(phase_inc), 258);
    check("rst_sym_count", int'(sym_count), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_cur_bit", int'(cur_bit), 0);
    reset_n = 1'b1;
    repeat (5) tick();
    check("steady_busy", int'(busy), 0);
    check("steady_sym_count", int'(sym_count), 0);

    // ASK ramp
    lfsr_word = 5'b00001;
    sin_in = -12'sd3; tick();
    check("ask_busy0", int'(busy), 1);
    sin_in = -12'sd2; tick();
    check("ask_busy1", int'(busy), 1);
    sin_in = -12'sd1; tick();
    check("ask_busy2", int'(busy), 1);
    sin_in = 12'sd0;  tick();
    exp_sc++;
    check("ask_apply_busy", int'(busy), 0);
    check("ask_apply_out", int'(mod_out), 0);
    check("ask_cur_bit", int'(cur_bit), 1);
    check("ask_sym_count", int'(sym_count), exp_sc);
    sin_in = 12'sd1;  tick();
    check("ask_out_1", int'(mod_out), 1);
    lfsr_word = 5'b00010;
    sin_in = -12'sd5; tick();
    check("ask_pend_out", int'(mod_out), -5);
    sin_in = 12'sd5;  tick();
    exp_sc++;
    check("ask_bit0_out", int'(mod_out), 0);
    sin_in = 12'sd7;  tick();
    check("ask_bit0_out2", int'(mod_out), 0);
    check("ask_bit0_cur", int'(cur_bit), 0);
    check("ask_sym_count2", int'(sym_count), exp_sc);

    // vector table: apply symbol, then one sample in that mode
    for (int i = 0; i < 11; i++) begin
      apply_word(vecs[i].word, vecs[i].mode);
      exp_sc++;
      sin_in = W'(vecs[i].sin_after);
      tick();
      check($sformatf("vec%0d_mod_out", i), int'(mod_out), vecs[i].exp_out);
      check($sformatf("vec%0d_phase_inc", i), int'(phase_inc), vecs[i].exp_inc);
      check($sformatf("vec%0d_cur_bit", i), int'(cur_bit), vecs[i].exp_bit);
    end
    check("table_sym_count", int'(sym_count), exp_sc);

    // FSK and mode hold in RUN
    apply_word(5'b11011, 2'd1);
    exp_sc++;
    check("fsk_hi", int'(phase_inc), 430);
    mod_sel = 2'd0;
    sin_in  = 12'sd300;
    repeat (3) tick();
    check("fsk_hold_inc", int'(phase_inc), 430);
    check("fsk_hold_out", int'(mod_out), 300);
    apply_word(5'b11100, 2'd1);
    exp_sc++;
    check("fsk_lo", int'(phase_inc), 258);
    check("fsk_lo_bit", int'(cur_bit), 0);

    // timeout with no crossing
    mod_sel   = 2'd0;
    sin_in    = 12'sd100;
    lfsr_word = 5'b10001;
    tick();
    n = 0;
    while (busy && n < TO + 100) begin
      n++;
      tick();
    end
    exp_sc++;
    check("timeout_busy_cycles", n, TO);
    check("timeout_sym_count", int'(sym_count), exp_sc);
    check("timeout_mod_out", int'(mod_out), 100);

    // two words within one PENDING
    lfsr_word = 5'b10011; tick();
    tick();
    tick();
    lfsr_word = 5'b10100; tick();
    check("two_words_busy", int'(busy), 1);
    sin_in = -12'sd1; tick();
    sin_in = 12'sd0;  tick();
    exp_sc++;
    check("two_words_bit", int'(cur_bit), 0);
    check("two_words_busy_after", int'(busy), 0);
    check("two_words_sym_count", int'(sym_count), exp_sc);

    // crossing on the timeout cycle
    sin_in    = 12'sd100;
    lfsr_word = 5'b11110;
    tick();
    repeat (TO - 2) tick();
    sin_in = -12'sd1; tick();
    check("zc_to_busy_before", int'(busy), 1);
    sin_in = 12'sd0;  tick();
    exp_sc++;
    check("zc_to_busy", int'(busy), 0);
    check("zc_to_sym_count", int'(sym_count), exp_sc);
    check("zc_to_bit", int'(cur_bit), 0);
    repeat (2) tick();
    check("zc_to_sym_count_hold", int'(sym_count), exp_sc);
    check("zc_to_busy_hold", int'(busy), 0);

    // new word in the apply cycle
    mod_sel   = 2'd1;
    sin_in    = 12'sd100;
    lfsr_word = 5'b10110;
    tick();
    sin_in = -12'sd1; tick();
    lfsr_word = 5'b10111;
    sin_in = 12'sd0;  tick();
    exp_sc++;
    check("late_word_bit", int'(cur_bit), 1);
    check("late_word_inc", int'(phase_inc), 430);
    check("late_word_sym_count", int'(sym_count), exp_sc);
    sin_in = 12'sd50; tick();
    check("late_word_busy", int'(busy), 0);
    check("late_word_out", int'(mod_out), 50);

    // reset mid-PENDING
    sin_in    = 12'sd100;
    lfsr_word = 5'b11000;
    tick();
    check("midrst_busy_before", int'(busy), 1);
    reset_n   = 1'b0;
    lfsr_word = 5'd0;
    tick();
    tick();
    check("midrst_mod_out", int'(mod_out), 0);
    check("midrst_phase_inc", int'(phase_inc), 258);
    check("midrst_sym_count", int'(sym_count), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_cur_bit", int'(cur_bit), 0);
    reset_n = 1'b1;
    repeat (3) tick();
    check("midrst_idle_busy", int'(busy), 0);
    check("midrst_idle_sym", int'(sym_count), 0);

    // sym_count wrap
    for (int i = 0; i < 255; i++) begin
      apply_word((i % 2 == 0) ? 5'b00001 : 5'b00010, 2'd0);
    end
    check("wrap_255", int'(sym_count), 255);
    apply_word(5'b00010, 2'd0);
    check("wrap_0", int'(sym_count), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/lfsr_modulator.md
Name: lfsr_modulator

Overview:
- Consumes the 5-bit LFSR word after it has been synchronised into the fast_clk domain.
- Uses bit 0 of each new word as the current symbol, and modulates the DDS carrier samples with it using ASK, FSK, BPSK or raw LFSR mode.
- Symbol changes are applied only at a rising zero crossing of the carrier, so the output never jumps mid-cycle. A timeout forces the change if no crossing arrives.
- Output drives the DAC/scope path; phase_inc drives the DDS phase accumulator.

Parameters:
W, 12, signed sample width of sin_in and mod_out.
F_CARRIER, 32'd258, DDS phase increment used in ASK, BPSK and raw modes (3 Hz at 50 MHz).
F_LO, 32'd258, FSK increment when the symbol is 0.
F_HI, 32'd430, FSK increment when the symbol is 1 (5 Hz at 50 MHz).
ZC_TIMEOUT, 4096, maximum cycles in PENDING before the symbol is applied anyway (must be at least 2).

Ports:
fast_clk  input  1  sole clock; all logic on posedge.
reset_n  input  1  synchronous, active-low reset.
lfsr_word  input  5  synchronised LFSR word; stable for many cycles between updates.
mod_sel  input  2  0=ASK, 1=FSK, 2=BPSK, 3=RAW.
sin_in  input  W  signed DDS sine sample.
mod_out  output  W  signed modulated sample, registered.
phase_inc  output  32  DDS increment, registered.
cur_bit  output  1  symbol currently applied.
busy  output  1  high while in PENDING.
sym_count  output  8  count of applied symbols; wraps 255 to 0.

Behaviour:
- Reset: when reset_n=0 at a clock edge, all of the following take their reset values:
  - mod_out=0, phase_inc=F_CARRIER, cur_bit=0, busy=0, sym_count=0.
  - prev_word=0, sin_prev=0, timeout counter=0, state=IDLE.
  - This applies from any state, including mid-PENDING; the pending symbol is discarded.
- New-word detection: new_word = (lfsr_word != prev_word). prev_word updates every cycle. A word of 0 never occurs from the LFSR, so the first real word always triggers.
- Zero crossing: zc = sin_prev[W-1] & ~sin_in[W-1], i.e. the previous sample was negative and the current sample is >= 0. sin_prev updates every cycle.
- FSM states:
  - IDLE: no symbol yet; mod_out=0. On new_word, latch pend_bit=lfsr_word[0] and go to PENDING.
  - RUN: on new_word, latch pend_bit and go to PENDING.
  - PENDING: busy=1; the counter increments each cycle.
    - Exit condition: zc, or counter == ZC_TIMEOUT-1. The cycle in which the exit condition is met is the "apply" cycle.
    - At the apply edge: cur_bit<=pend_bit; active_mode<=mod_sel; sym_count+=1; counter<=0; go to RUN.
    - A new_word while in PENDING overwrites pend_bit; the counter is not restarted.
    - zc and timeout in the same cycle produce exactly one apply.
    - new_word in the apply cycle applies the new bit, still with a single increment.
- Mode sampling: mod_sel is sampled only at apply, never while in RUN.
- Output datapath (registered; the apply-cycle sample uses the new bit and mode):
  - ASK: bit ? sin_in : 0.
  - FSK: sin_in, with phase_inc = bit ? F_HI : F_LO.
  - BPSK: bit ? sin_in : -sin_in. Negating -2^(W-1) saturates to 2^(W-1)-1.
  - RAW: bit ? 2^(W-1)-1 : -2^(W-1).
  - phase_inc = F_CARRIER in every mode except FSK.
- Latency: mod_out reflects sin_in from the previous edge (1 cycle). Symbol change takes 1 cycle after the crossing sample.

Decomposition:
- Shared package mod_pkg holds:
  - typedef enum mod_sel_t {MOD_ASK, MOD_FSK, MOD_BPSK, MOD_RAW}.
  - typedef enum state_t {IDLE, RUN, PENDING}.
  - Default constants F_CARRIER, F_LO and F_HI.
- Sub-module zero_cross_det (fast_clk, reset_n, sample in, zc out): holds sin_prev and the sign comparison.
- The FSM and datapath stay in lfsr_modulator.

Test Plan:
- Reset: hold reset_n=0 for 2 cycles while busy is mid-PENDING -> mod_out=0, phase_inc=258, sym_count=0, busy=0. After release, a steady word produces no activity until lfsr_word changes.
- ASK:
  - mod_sel=0, lfsr_word 0->5'b00001, sin_in ramp -3,-2,-1,0,1 -> busy high until the 0 sample.
  - Next edge gives mod_out=0, then 1. sym_count=1, cur_bit=1.
  - Word 5'b00010 with the next crossing -> mod_out=0 thereafter.
- BPSK: mod_sel=2, bit=0 applied; sin_in=1000 -> mod_out=-1000; sin_in=-2048 -> mod_out=+2047 (saturated).
- FSK: mod_sel=1, bit 1 applied -> phase_inc=430; next word with bit 0 after a crossing -> phase_inc=258. Switching mod_sel to 0 in RUN changes nothing until the next apply.
- Timeout: sin_in held at +100, new word -> busy stays high exactly ZC_TIMEOUT cycles, then drops; sym_count increments by 1.
- Collisions:
  - Two words (bit 1 then bit 0) arrive within PENDING -> only bit 0 is applied, with a single increment.
  - zc coinciding with counter=ZC_TIMEOUT-1 -> single apply.
  - sym_count wraps from 255 to 0.
